// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: ball position/direction, scoring and serve/pause/game-over
// sequencing for the 64x64 pong field. Reacts to the collision block's event
// flags on each movement step and drives the next bx/by back out.
//
// Optional build macro BALL_SPEEDUP_EN: adds a 3-bit rally counter. After four
// paddle returns in one rally the ball moves two cells per axis per step.
//
// Handshake note: there is no valid/ready traffic here. step is a one-cycle
// qualifier; paddle_hit/wall_hit/miss_left/miss_right are only looked at on
// cycles where step=1 and the FSM is in PLAY. serve_btn is a level.
module pong_ball_ctrl #(
    parameter int FIELD_W     = 64,
    parameter int FIELD_H     = 64,
    parameter int START_X     = 31,
    parameter int START_Y     = 31,
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 4,
    parameter int PAUSE_STEPS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic               serve_btn,
    input  logic               paddle_hit,
    input  logic               wall_hit,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic [5:0]         bx,
    output logic [5:0]         by,
    output logic               dx,
    output logic               dy,
    output logic [SCORE_W-1:0] sc1,
    output logic [SCORE_W-1:0] sc2,
    output logic [2:0]         state,
    output logic               point_pulse,
    output logic               game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int CNT_W = (PAUSE_STEPS > 1) ? $clog2(PAUSE_STEPS) : 1;

    localparam logic [6:0]         X_MAX    = 7'(FIELD_W - 1);
    localparam logic [6:0]         Y_MAX    = 7'(FIELD_H - 1);
    localparam logic [5:0]         X_START  = 6'(START_X);
    localparam logic [5:0]         Y_START  = 6'(START_Y);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(PAUSE_STEPS - 1);

    state_t           st;
    logic [CNT_W-1:0] pause_cnt;
    logic             lost_left;   // 1 when the last point came from miss_left

    logic       dx_n;
    logic       dy_n;
    logic [6:0] mv;
    logic [6:0] x_sum;
    logic [6:0] y_sum;
    logic [5:0] nx;
    logic [5:0] ny;

    assign state = st;

`ifdef BALL_SPEEDUP_EN
    logic [2:0] rally;
    // Distance per move: doubles once the rally counter has saturated.
    always_comb begin
        mv = (rally == 3'd4) ? 7'd2 : 7'd1;
    end
`else
    // Distance per move is always one cell.
    always_comb begin
        mv = 7'd1;
    end
`endif

    // Next direction and clamped next position for a normal (no-miss) step.
    always_comb begin
        dx_n  = dx ^ paddle_hit;
        dy_n  = dy ^ wall_hit;
        x_sum = {1'b0, bx} + mv;
        y_sum = {1'b0, by} + mv;
        if (dx_n) begin
            nx = (x_sum > X_MAX) ? X_MAX[5:0] : x_sum[5:0];
        end else begin
            nx = ({1'b0, bx} < mv) ? 6'd0 : (bx - mv[5:0]);
        end
        if (dy_n) begin
            ny = (y_sum > Y_MAX) ? Y_MAX[5:0] : y_sum[5:0];
        end else begin
            ny = ({1'b0, by} < mv) ? 6'd0 : (by - mv[5:0]);
        end
    end

    // Game FSM with registered ball, score and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_IDLE;
            bx          <= X_START;
            by          <= Y_START;
            dx          <= 1'b1;
            dy          <= 1'b1;
            sc1         <= '0;
            sc2         <= '0;
            point_pulse <= 1'b0;
            game_over   <= 1'b0;
            pause_cnt   <= '0;
            lost_left   <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            rally       <= 3'd0;
`endif
        end else begin
            point_pulse <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (serve_btn) st <= S_PLAY;
                end
                S_SERVE: begin
                    if (serve_btn) st <= S_PLAY;
                end
                S_PLAY: begin
                    if (step) begin
                        if (miss_left) begin
                            if (sc2 != WIN) sc2 <= sc2 + 1'b1;
                            point_pulse <= 1'b1;
                            lost_left   <= 1'b1;
                            pause_cnt   <= CNT_LOAD;
                            st          <= S_PAUSE;
`ifdef BALL_SPEEDUP_EN
                            rally       <= 3'd0;
`endif
                        end else if (miss_right) begin
                            if (sc1 != WIN) sc1 <= sc1 + 1'b1;
                            point_pulse <= 1'b1;
                            lost_left   <= 1'b0;
                            pause_cnt   <= CNT_LOAD;
                            st          <= S_PAUSE;
`ifdef BALL_SPEEDUP_EN
                            rally       <= 3'd0;
`endif
                        end else begin
                            dx <= dx_n;
                            dy <= dy_n;
                            bx <= nx;
                            by <= ny;
`ifdef BALL_SPEEDUP_EN
                            if (paddle_hit && rally != 3'd4) rally <= rally + 3'd1;
`endif
                        end
                    end
                end
                S_PAUSE: begin
                    if (step) begin
                        if (pause_cnt == '0) begin
                            if (sc1 == WIN || sc2 == WIN) begin
                                st        <= S_OVER;
                                game_over <= 1'b1;
                            end else begin
                                st <= S_SERVE;
                                bx <= X_START;
                                by <= Y_START;
                                dx <= ~lost_left;
                                dy <= 1'b1;
                            end
                        end else begin
                            pause_cnt <= pause_cnt - 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    if (serve_btn) begin
                        st        <= S_SERVE;
                        sc1       <= '0;
                        sc2       <= '0;
                        game_over <= 1'b0;
                        bx        <= X_START;
                        by        <= Y_START;
                        dx        <= 1'b1;
                        dy        <= 1'b1;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed testbench for pong_ball_ctrl (default build, no speed-up).
module tb_pong_ball_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       step;
    logic       serve_btn;
    logic       paddle_hit;
    logic       wall_hit;
    logic       miss_left;
    logic       miss_right;
    logic [5:0] bx;
    logic [5:0] by;
    logic       dx;
    logic       dy;
    logic [3:0] sc1;
    logic [3:0] sc2;
    logic [2:0] state;
    logic       point_pulse;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    pong_ball_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .step        (step),
        .serve_btn   (serve_btn),
        .paddle_hit  (paddle_hit),
        .wall_hit    (wall_hit),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .bx          (bx),
        .by          (by),
        .dx          (dx),
        .dy          (dy),
        .sc1         (sc1),
        .sc2         (sc2),
        .state       (state),
        .point_pulse (point_pulse),
        .game_over   (game_over)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs, then release them; outputs sampled 1 unit after the edge.
    task automatic cyc(input logic st, input logic pad, input logic wall,
                       input logic ml, input logic mr, input logic sv);
        step       = st;
        paddle_hit = pad;
        wall_hit   = wall;
        miss_left  = ml;
        miss_right = mr;
        serve_btn  = sv;
        @(posedge clk);
        #1;
        step       = 1'b0;
        paddle_hit = 1'b0;
        wall_hit   = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        serve_btn  = 1'b0;
    endtask

    task automatic plain_steps(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ball(input string tag, input logic [5:0] ex, input logic [5:0] ey,
                            input logic edx, input logic edy);
        chk({tag, "_bx"}, bx, ex);
        chk({tag, "_by"}, by, ey);
        chk({tag, "_dx"}, dx, edx);
        chk({tag, "_dy"}, dy, edy);
    endtask

    initial begin
        rst = 1'b1; step = 0; serve_btn = 0; paddle_hit = 0;
        wall_hit = 0; miss_left = 0; miss_right = 0;
        #12;
        // Reset values
        chk_ball("rst", 6'd31, 6'd31, 1'b1, 1'b1);
        chk("rst_state", state, 0);
        chk("rst_sc1", sc1, 0);
        chk("rst_sc2", sc2, 0);
        chk("rst_pulse", point_pulse, 0);
        chk("rst_over", game_over, 0);
        @(posedge clk); #1; rst = 1'b0;

        // IDLE without serve stays put, steps ignored
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_hold_state", state, 0);
        chk("idle_hold_bx", bx, 31);

        // Test 1: serve then 3 plain steps
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_play", state, 2);
        plain_steps(3);
        chk_ball("t1", 6'd34, 6'd34, 1'b1, 1'b1);

        // Events without step are ignored
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_ball("nostep", 6'd34, 6'd34, 1'b1, 1'b1);
        chk("nostep_state", state, 2);
        chk("nostep_sc2", sc2, 0);

        // Test 2 path: steer to (40,63) moving right/down, bottom clamp on the way
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ball("t2_flip", 6'd33, 6'd35, 1'b0, 1'b1);
        plain_steps(11);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ball("t2_back", 6'd23, 6'd47, 1'b1, 1'b1);
        plain_steps(17);
        chk_ball("t2_clamp", 6'd40, 6'd63, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_ball("t2_wall", 6'd41, 6'd62, 1'b1, 1'b0);

        // Test 3 path: fresh game, steer to (2,20) moving left/up
        do_reset();
        chk("t3_rst_state", state, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        plain_steps(8);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        plain_steps(19);
        chk_ball("t3_pre", 6'd2, 6'd20, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_ball("t3_both", 6'd3, 6'd21, 1'b1, 1'b1);

        // Test 4: simultaneous misses -> only player 2 scores
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_sc2", sc2, 1);
        chk("t4_sc1", sc1, 0);
        chk("t4_state", state, 3);
        chk("t4_pulse", point_pulse, 1);
        chk_ball("t4_frozen", 6'd3, 6'd21, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_pulse_off", point_pulse, 0);
        // serve_btn is ignored in PAUSE
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_pause_serve", state, 3);
        plain_steps(14);
        chk("t4_pause_15", state, 3);
        plain_steps(1);
        chk("t4_serve", state, 1);
        chk_ball("t4_recentre", 6'd31, 6'd31, 1'b0, 1'b1);

        // Test 5: seven points for player 1 -> game over
        for (int p = 1; p <= 7; p++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("t5_play", state, 2);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("t5_sc1", sc1, p);
            chk("t5_pulse", point_pulse, 1);
            plain_steps(16);
            chk("t5_after_pause", state, (p == 7) ? 4 : 1);
        end
        chk("t5_over", game_over, 1);
        chk("t5_sc2_hold", sc2, 1);
        chk("t5_sc1_max", sc1, 7);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_reserve_state", state, 1);
        chk("t5_reserve_sc1", sc1, 0);
        chk("t5_reserve_sc2", sc2, 0);
        chk("t5_reserve_over", game_over, 0);
        chk_ball("t5_reserve", 6'd31, 6'd31, 1'b1, 1'b1);

        // Test 6: score a point, resume play, then async reset between edges
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        plain_steps(16);
        chk_ball("t6_serve", 6'd31, 6'd31, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        plain_steps(1);
        chk_ball("t6_pre", 6'd29, 6'd33, 1'b0, 1'b1);
        chk("t6_pre_sc1", sc1, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_ball("t6_async", 6'd31, 6'd31, 1'b1, 1'b1);
        chk("t6_async_state", state, 0);
        chk("t6_async_sc1", sc1, 0);
        chk("t6_async_pulse", point_pulse, 0);
        chk("t6_async_over", game_over, 0);
        @(posedge clk); #1; rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
